// File: rtl/vcxo_pi_discipliner.sv
// rtl/vcxo_pi_discipliner.sv - VCXO frequency discipliner: gated Gray-count measurement, PI loop, PWM pump.
module vcxo_pi_discipliner #(
    parameter int CNT_W        = 32,
    parameter int GATE_CYCLES  = 49152,
    parameter int TARGET_COUNT = 122880,
    parameter int PWM_W        = 16,
    parameter int PWM_INIT     = 30000,
    parameter int KP_SHIFT     = 3,
    parameter int KI_SHIFT     = 6,
    parameter int LOCK_TOL     = 2,
    parameter int LOCK_COUNT   = 8
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               enable_in,
    input  logic [CNT_W-1:0]   vcxo_gray_in,
    input  logic [7:0]         correction_in,
    output logic [23:0]        freq_error,
    output logic [PWM_W-1:0]   pwm_duty,
    output logic               pump,
    output logic               meas_valid,
    output logic               locked
);

    localparam int EW = ((CNT_W > 24) ? CNT_W : 24) + 2;
    localparam int DW = ((PWM_W > 25) ? PWM_W : 25) + 3;
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int LW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [EW-1:0] ERR_MAX = {{(EW-24){1'b0}}, 24'h7FFFFF};
    localparam logic signed [EW-1:0] ERR_MIN = {{(EW-24){1'b1}}, 24'h800000};
    localparam logic signed [EW-1:0] TARGET  = EW'(TARGET_COUNT);
    localparam logic signed [DW-1:0] DUTY_MAX = {{(DW-PWM_W){1'b0}}, {PWM_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, GATE, CALC, UPDATE} state_t;

    state_t             state, state_next;
    logic [GW-1:0]      gate_cnt;
    logic [CNT_W-1:0]   vcxo_bin, start_cnt, end_cnt;
    logic [PWM_W-1:0]   integ, pwm_cnt;
    logic [LW-1:0]      lock_cnt;
    logic               gate_last;
    logic               sample_start, sample_end, do_calc, do_update;

    always_comb begin
        vcxo_bin[CNT_W-1] = vcxo_gray_in[CNT_W-1];
        for (int i = CNT_W - 2; i >= 0; i--)
            vcxo_bin[i] = vcxo_bin[i+1] ^ vcxo_gray_in[i];
    end

    assign gate_last = (gate_cnt == GW'(GATE_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (reset_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = GATE;
                GATE:    state_next = gate_last ? CALC : GATE;
                CALC:    state_next = UPDATE;
                UPDATE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        sample_start = 1'b0;
        sample_end   = 1'b0;
        do_calc      = 1'b0;
        do_update    = 1'b0;
        if (enable_in) begin
            case (state)
                IDLE:    sample_start = 1'b1;
                GATE:    sample_end   = gate_last;
                CALC:    do_calc      = 1'b1;
                UPDATE:  do_update    = 1'b1;
                default: sample_start = 1'b0;
            endcase
        end
    end

    // Measurement error; modular subtraction handles count wrap inside the gate.
    logic [CNT_W-1:0]        delta;
    logic signed [EW-1:0]    delta_ext, corr_ext, err_wide;
    logic [23:0]             err_sat;

    always_comb begin
        delta     = end_cnt - start_cnt;
        delta_ext = {{(EW-CNT_W){1'b0}}, delta};
        corr_ext  = {{(EW-8){correction_in[7]}}, correction_in};
        err_wide  = delta_ext - TARGET + corr_ext;
        if (err_wide > ERR_MAX)
            err_sat = 24'h7FFFFF;
        else if (err_wide < ERR_MIN)
            err_sat = 24'h800000;
        else
            err_sat = err_wide[23:0];
    end

    // PI update works on the registered error so it lines up with meas_valid.
    logic signed [23:0]    err_s, ishift, istep;
    logic [23:0]           abs_err, pmag;
    logic signed [DW-1:0]  integ_wide, duty_wide, integ_ext, pstep_ext;
    logic [PWM_W-1:0]      integ_next, duty_next;

    always_comb begin
        err_s   = $signed(freq_error);
        ishift  = err_s >>> KI_SHIFT;
        if (ishift == 24'sd0 && err_s != 24'sd0)
            istep = err_s[23] ? -24'sd1 : 24'sd1;
        else
            istep = ishift;
        abs_err = err_s[23] ? 24'(-err_s) : freq_error;
        pmag    = abs_err >> KP_SHIFT;

        integ_wide = $signed({{(DW-PWM_W){1'b0}}, integ}) - $signed({{(DW-24){istep[23]}}, istep});
        if (integ_wide < 0)
            integ_next = '0;
        else if (integ_wide > DUTY_MAX)
            integ_next = '1;
        else
            integ_next = integ_wide[PWM_W-1:0];

        integ_ext = $signed({{(DW-PWM_W){1'b0}}, integ_next});
        pstep_ext = $signed({{(DW-24){1'b0}}, pmag});
        duty_wide = err_s[23] ? integ_ext + pstep_ext : integ_ext - pstep_ext;
        if (duty_wide < 0)
            duty_next = '0;
        else if (duty_wide > DUTY_MAX)
            duty_next = '1;
        else
            duty_next = duty_wide[PWM_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            gate_cnt   <= '0;
            start_cnt  <= '0;
            end_cnt    <= '0;
            freq_error <= '0;
            integ      <= PWM_W'(PWM_INIT);
            pwm_duty   <= PWM_W'(PWM_INIT);
            meas_valid <= 1'b0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
        end else begin
            meas_valid <= do_update;
            if (sample_start) begin
                start_cnt <= vcxo_bin;
                gate_cnt  <= '0;
            end else if (state == GATE) begin
                gate_cnt  <= gate_cnt + GW'(1);
            end
            if (sample_end)
                end_cnt <= vcxo_bin;
            if (do_calc)
                freq_error <= err_sat;
            if (do_update) begin
                integ    <= integ_next;
                pwm_duty <= duty_next;
                if (abs_err <= 24'(LOCK_TOL)) begin
                    if (lock_cnt != LW'(LOCK_COUNT))
                        lock_cnt <= lock_cnt + LW'(1);
                    if (lock_cnt >= LW'(LOCK_COUNT - 1))
                        locked <= 1'b1;
                end else if (abs_err <= 24'(2 * LOCK_TOL)) begin
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
            if (!enable_in) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pwm_cnt <= '0;
            pump    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            pump    <= (pwm_cnt < pwm_duty);
        end
    end

endmodule

// File: tb/tb_vcxo_pi_discipliner.sv
// tb/tb_vcxo_pi_discipliner.sv - directed bench for vcxo_pi_discipliner with a linear-rate VCXO count model.
module tb_vcxo_pi_discipliner;

    localparam int G = 100;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic [31:0] vcxo_gray_in;
    logic [7:0]  correction_in;
    logic [23:0] freq_error;
    logic [7:0]  pwm_duty;
    logic        pump;
    logic        meas_valid;
    logic        locked;

    int          errors = 0;
    int          checks = 0;
    longint      base, t, rate;
    logic [31:0] vcxo_cur;
    int          lat;
    int          cnt;
    logic [23:0] prev_fe;
    logic [7:0]  prev_duty;
    int          duty_tab [7] = '{206, 222, 238, 254, 255, 255, 255};

    vcxo_pi_discipliner #(
        .CNT_W(32), .GATE_CYCLES(G), .TARGET_COUNT(250), .PWM_W(8), .PWM_INIT(128),
        .KP_SHIFT(2), .KI_SHIFT(4), .LOCK_TOL(2), .LOCK_COUNT(3)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
        .vcxo_gray_in(vcxo_gray_in), .correction_in(correction_in),
        .freq_error(freq_error), .pwm_duty(pwm_duty), .pump(pump),
        .meas_valid(meas_valid), .locked(locked)
    );

    always #5 clk_in = ~clk_in;

    // Count advances by exactly rate per G cycles, so any G-cycle window sees delta == rate.
    task automatic update_vcxo();
        vcxo_cur     = 32'(base + (t * rate) / G);
        vcxo_gray_in = vcxo_cur ^ (vcxo_cur >> 1);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        t++;
        update_vcxo();
    endtask

    task automatic set_rate(input longint r);
        base = longint'(vcxo_cur);
        t    = 0;
        rate = r;
        update_vcxo();
    endtask

    task automatic set_count(input logic [31:0] v);
        base = longint'(v);
        t    = 0;
        update_vcxo();
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_meas();
        lat = 0;
        do begin
            prev_fe   = freq_error;
            prev_duty = pwm_duty;
            tick();
            lat++;
        end while (!meas_valid && lat < 400);
        chk("meas_seen", meas_valid, 1);
    endtask

    task automatic do_reset();
        enable_in = 1'b0;
        reset_in  = 1'b1;
        repeat (3) tick();
        reset_in  = 1'b0;
    endtask

    initial begin
        reset_in      = 1'b1;
        enable_in     = 1'b0;
        correction_in = 8'd0;
        base = 0; t = 0; rate = 250;
        update_vcxo();
        repeat (3) tick();
        chk("rst_fe", $signed(freq_error), 0);
        chk("rst_duty", pwm_duty, 128);
        chk("rst_mv", meas_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pump", pump, 0);
        reset_in = 1'b0;

        // Nominal rate: zero error, lock on third measurement
        enable_in = 1'b1;
        wait_meas();
        chk("nom1_fe", $signed(freq_error), 0);
        chk("nom1_duty", pwm_duty, 128);
        chk("nom1_locked", locked, 0);
        wait_meas();
        chk("nom2_locked", locked, 0);
        wait_meas();
        chk("nom3_duty", pwm_duty, 128);
        chk("nom3_locked", locked, 1);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pump) cnt++;
        end
        chk("pump_high_256", cnt, 128);

        // Small positive error: istep floors to 0 and is forced to +1
        wait_meas();
        correction_in = 8'd3;
        wait_meas();
        chk("c3_fe", $signed(freq_error), 3);
        chk("c3_duty", pwm_duty, 127);
        chk("c3_locked", locked, 1);
        correction_in = 8'd0;
        wait_meas();
        chk("c0_duty", pwm_duty, 127);
        chk("c0_locked", locked, 1);

        // Abort at gate cycle 50
        tick();
        repeat (50) tick();
        enable_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (meas_valid) cnt++;
        end
        chk("abort_no_mv", cnt, 0);
        chk("abort_duty", pwm_duty, 127);
        chk("abort_fe", $signed(freq_error), 0);
        chk("abort_locked", locked, 0);
        enable_in = 1'b1;
        wait_meas();
        chk("reen_latency", lat, G + 3);
        chk("reen_duty", pwm_duty, 127);
        chk("reen_locked", locked, 0);

        // Count wraps through zero inside the gate
        set_count(32'hFFFFFF80);
        wait_meas();
        chk("wrap_fe", $signed(freq_error), 0);
        chk("wrap_duty", pwm_duty, 127);

        // Delta 234, then delta 250 with correction -16
        do_reset();
        set_rate(234);
        enable_in = 1'b1;
        wait_meas();
        chk("d234_fe", $signed(freq_error), -16);
        chk("d234_duty", pwm_duty, 133);
        chk("d234_fe_early", $signed(prev_fe), -16);
        chk("d234_duty_late", prev_duty, 128);
        chk("d234_locked", locked, 0);
        do_reset();
        set_rate(250);
        correction_in = 8'hF0;
        enable_in = 1'b1;
        wait_meas();
        chk("corr_fe", $signed(freq_error), -16);
        chk("corr_duty", pwm_duty, 133);

        // Stalled VCXO: duty climbs and clamps at 255
        do_reset();
        set_rate(0);
        correction_in = 8'd0;
        enable_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_meas();
            chk($sformatf("stall%0d_fe", i), $signed(freq_error), -250);
            chk($sformatf("stall%0d_duty", i), pwm_duty, duty_tab[i]);
        end
        chk("stall_locked", locked, 0);

        // Reset mid-gate with enable still high
        tick();
        repeat (40) tick();
        reset_in = 1'b1;
        tick();
        chk("mrst_fe", $signed(freq_error), 0);
        chk("mrst_duty", pwm_duty, 128);
        chk("mrst_mv", meas_valid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_pump", pump, 0);
        reset_in  = 1'b0;
        enable_in = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
